// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the parametrised VGA timing generator.
// Defaults describe the standard 640x480@60 mode.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam logic SYNC_ACTIVE_LOW = 1'b0;

  function automatic int h_total(int disp, int front, int sync, int back);
    return disp + front + sync + back;
  endfunction

  function automatic int v_total(int disp, int front, int sync, int back);
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle between the generator (master) and pixel logic (slave).
// The consumer owns the pixel clock enable; the generator drives everything else.
interface vga_timing_gen_if #(
  parameter int CW      = 10,
  parameter int FRAME_W = 16
);
  logic               ce;
  logic [CW-1:0]      hpos;
  logic [CW-1:0]      vpos;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  ce,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );

  modport slave (
    output ce,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Clock-enable-qualified shift register of configurable depth; depth 0 is a wire.
// All stages reset to RST_VAL so a reset flushes the pipe to inactive levels.
module delay_line #(
  parameter int           W       = 3,
  parameter int           DEPTH   = 0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = &{1'b0, clk, reset, ce, RST_VAL};
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stg_p [DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stg_p[i] <= RST_VAL;
        end else if (ce) begin
          stg_p[0] <= d;
          for (int i = 1; i < DEPTH; i++) stg_p[i] <= stg_p[i-1];
        end
      end

      assign q = stg_p[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: counters, sync/DE with PIPE_DELAY alignment stages.
// Define VGA_TIMING_FRAME_CNT_EN to build the frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY  = H_DISPLAY_DEF,
  parameter int   H_FRONT    = H_FRONT_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BACK     = H_BACK_DEF,
  parameter int   V_DISPLAY  = V_DISPLAY_DEF,
  parameter int   V_FRONT    = V_FRONT_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BACK     = V_BACK_DEF,
  parameter logic HSYNC_POL  = SYNC_ACTIVE_LOW,
  parameter logic VSYNC_POL  = SYNC_ACTIVE_LOW,
  parameter int   PIPE_DELAY = 0,
  parameter int   CW         = 10,
  parameter int   FRAME_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Window bounds carry one extra bit so an end equal to 2^CW stays representable.
  localparam logic [CW:0] HS_LO = (CW+1)'(H_DISPLAY + H_FRONT);
  localparam logic [CW:0] HS_HI = (CW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW:0] VS_LO = (CW+1)'(V_DISPLAY + V_FRONT);
  localparam logic [CW:0] VS_HI = (CW+1)'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [CW:0] H_VIS = (CW+1)'(H_DISPLAY);
  localparam logic [CW:0] V_VIS = (CW+1)'(V_DISPLAY);

  function automatic logic in_window(logic [CW-1:0] p, logic [CW:0] lo, logic [CW:0] hi);
    return ({1'b0, p} >= lo) && ({1'b0, p} < hi);
  endfunction

  logic [CW-1:0] h_q, v_q;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          h_wrap, v_wrap;
  logic          hs_p0, vs_p0, de_p0;
  logic [2:0]    sync_q;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_nxt  = h_wrap ? '0 : h_q + CW'(1);
    v_nxt  = v_q;
    if (h_wrap) v_nxt = v_wrap ? '0 : v_q + CW'(1);
  end

  // Stage 0: decoded from the next position so it lines up with hpos/vpos.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_p0 <= ~HSYNC_POL;
      vs_p0 <= ~VSYNC_POL;
      de_p0 <= 1'b0;
    end else if (bus.ce) begin
      h_q   <= h_nxt;
      v_q   <= v_nxt;
      hs_p0 <= in_window(h_nxt, HS_LO, HS_HI) ? HSYNC_POL : ~HSYNC_POL;
      vs_p0 <= in_window(v_nxt, VS_LO, VS_HI) ? VSYNC_POL : ~VSYNC_POL;
      de_p0 <= ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
    end
  end

  delay_line #(
    .W       (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({~HSYNC_POL, ~VSYNC_POL, 1'b0})
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .ce    (bus.ce),
    .d     ({hs_p0, vs_p0, de_p0}),
    .q     (sync_q)
  );

  assign bus.hpos        = h_q;
  assign bus.vpos        = v_q;
  assign bus.hsync       = sync_q[2];
  assign bus.vsync       = sync_q[1];
  assign bus.display_on  = sync_q[0];
  assign bus.line_start  = bus.ce && (h_q == '0);
  assign bus.frame_start = bus.ce && (h_q == '0) && (v_q == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
    end else if (bus.ce && h_wrap && v_wrap) begin
      frame_q <= frame_q + FRAME_W'(1);
    end
  end

  assign bus.frame_cnt = frame_q;
`else
  assign bus.frame_cnt = {FRAME_W{1'b0}};
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: four configurations driven with shared reset/ce.
// Expected outputs derive from the count of ce-steps since reset; honours VGA_TIMING_FRAME_CNT_EN.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    int hd; int hf; int hs; int hb;
    int vd; int vf; int vs; int vb;
    int hp; int vp; int pd; int fw;
  } cfg_t;

  typedef struct packed {
    int hpos; int vpos; int fc;
    bit hs; bit vs; bit de; bit ls; bit fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10), .FRAME_W(16)) if0 ();
  vga_timing_gen_if #(.CW(10), .FRAME_W(16)) if1 ();
  vga_timing_gen_if #(.CW(3),  .FRAME_W(2))  if2 ();
  vga_timing_gen_if #(.CW(10), .FRAME_W(16)) if3 ();

  assign if0.ce = ce;
  assign if1.ce = ce;
  assign if2.ce = ce;
  assign if3.ce = ce;

  // 0: defaults
  vga_timing_gen u_dut0 (.clk(clk), .reset(reset), .bus(if0));

  // 1: defaults, three alignment stages, active-high hsync
  vga_timing_gen #(.PIPE_DELAY(3), .HSYNC_POL(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  // 2: tiny 8x6 raster, counters exactly fill CW, two-bit frame counter
  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .VSYNC_POL(1'b1), .PIPE_DELAY(2), .CW(3), .FRAME_W(2)
  ) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  // 3: short lines with default vertical timing, so a full frame fits the run
  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2)
  ) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  function automatic cfg_t cfg_of(int d);
    cfg_t c;
    c = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33,
          hp:0, vp:0, pd:0, fw:16};
    case (d)
      1: begin c.pd = 3; c.hp = 1; end
      2: c = '{hd:4, hf:1, hs:2, hb:1, vd:3, vf:1, vs:1, vb:1,
               hp:0, vp:1, pd:2, fw:2};
      3: begin c.hd = 8; c.hf = 2; c.hs = 4; c.hb = 2; end
      default: ;
    endcase
    return c;
  endfunction

  // k = ce-qualified edges since the last reset; outputs follow directly from it.
  function automatic exp_t model(cfg_t c, longint k, bit cev);
    exp_t   e;
    longint ht, vt, line, j, hj, vj;
    ht     = c.hd + c.hf + c.hs + c.hb;
    vt     = c.vd + c.vf + c.vs + c.vb;
    e.hpos = int'(k % ht);
    line   = k / ht;
    e.vpos = int'(line % vt);
`ifdef VGA_TIMING_FRAME_CNT_EN
    e.fc   = int'((line / vt) % (longint'(1) << c.fw));
`else
    e.fc   = 0;
`endif
    e.hs = !bit'(c.hp);
    e.vs = !bit'(c.vp);
    e.de = 1'b0;
    j    = k - c.pd;
    if (j >= 1) begin
      hj = j % ht;
      vj = (j / ht) % vt;
      if (hj >= c.hd + c.hf && hj < c.hd + c.hf + c.hs) e.hs = bit'(c.hp);
      if (vj >= c.vd + c.vf && vj < c.vd + c.vf + c.vs) e.vs = bit'(c.vp);
      e.de = (hj < c.hd) && (vj < c.vd);
    end
    e.ls = cev && (e.hpos == 0);
    e.fs = e.ls && (e.vpos == 0);
    return e;
  endfunction

  exp_t   act [4];
  exp_t   sbq [4][$];
  longint k [4];
  int     n_vec = 0;
  int     n_bad = 0;

  always_comb begin
    act[0] = '{hpos: int'(if0.hpos), vpos: int'(if0.vpos), fc: int'(if0.frame_cnt),
               hs: if0.hsync, vs: if0.vsync, de: if0.display_on,
               ls: if0.line_start, fs: if0.frame_start};
    act[1] = '{hpos: int'(if1.hpos), vpos: int'(if1.vpos), fc: int'(if1.frame_cnt),
               hs: if1.hsync, vs: if1.vsync, de: if1.display_on,
               ls: if1.line_start, fs: if1.frame_start};
    act[2] = '{hpos: int'(if2.hpos), vpos: int'(if2.vpos), fc: int'(if2.frame_cnt),
               hs: if2.hsync, vs: if2.vsync, de: if2.display_on,
               ls: if2.line_start, fs: if2.frame_start};
    act[3] = '{hpos: int'(if3.hpos), vpos: int'(if3.vpos), fc: int'(if3.frame_cnt),
               hs: if3.hsync, vs: if3.vsync, de: if3.display_on,
               ls: if3.line_start, fs: if3.frame_start};
  end

  // Monitor: every edge presents a new output set; compare it against the queued expectation.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 4; d++) begin
      if (sbq[d].size() > 0) begin
        exp_t e;
        e = sbq[d].pop_front();
        n_vec++;
        if (act[d] != e) begin
          n_bad++;
          $display("FAIL dut%0d @%0t: got h=%0d v=%0d fc=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b, expected h=%0d v=%0d fc=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b",
                   d, $time, act[d].hpos, act[d].vpos, act[d].fc, act[d].hs, act[d].vs,
                   act[d].de, act[d].ls, act[d].fs, e.hpos, e.vpos, e.fc, e.hs, e.vs,
                   e.de, e.ls, e.fs);
        end
      end
    end
  end

  task automatic step(bit r, bit c);
    @(negedge clk);
    reset = r;
    ce    = c;
    for (int d = 0; d < 4; d++) begin
      if (r) k[d] = 0;
      else if (c) k[d] = k[d] + 1;
      sbq[d].push_back(model(cfg_of(d), k[d], c));
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) k[d] = 0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    @(posedge clk);
    #2;
    if (!(if0.hpos == '0 && if0.vpos == '0 && if0.hsync === 1'b1 &&
          if0.vsync === 1'b1 && if0.display_on === 1'b0)) begin
      n_bad++;
      $display("FAIL reset state @%0t: h=%0d v=%0d hs=%0b vs=%0b de=%0b",
               $time, if0.hpos, if0.vpos, if0.hsync, if0.vsync, if0.display_on);
    end

    fork
      begin : line_watch
        bit seen;
        seen = 1'b0;
        wait (if0.hpos != '0);
        fork
          begin
            wait (if0.line_start === 1'b1);
            seen = 1'b1;
          end
          repeat (1000) @(posedge clk);
        join_any
        disable fork;
        if (!seen) begin
          n_bad++;
          $display("FAIL timeout @%0t: no line_start within 1000 cycles", $time);
        end
      end
    join_none

    // Free run: several default lines, over a full frame of the short-line config.
    for (int i = 0; i < 9000; i++) step(1'b0, 1'b1);
    // Pixel clock at half rate.
    for (int i = 0; i < 2000; i++) step(1'b0, (i % 2) == 0);
    // Irregular enable with occasional mid-frame resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, c;
      r = ($urandom_range(0, 249) == 0);
      c = ($urandom_range(0, 3) != 0);
      step(r, c);
    end

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad != 0) $display("FAIL: %0d miscompares", n_bad);
    else            $display("PASS");
    $finish;
  end

endmodule
